// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: instruction constants, default
// word-address width and the next-PC select encoding.
package mips_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  // Source of the next PC value
  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_HOLD     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Control priority: flush > hold > load.
// Flush inserts a NOP bubble; hold and an idle cycle keep the contents.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pc_plus1,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc_plus1,
  output logic              o_valid
);

  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc_plus1;
  logic              r_valid;

  // Capture, squash or hold the fetched instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus1 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load && !i_hold) begin
      r_instr    <= i_instr;
      r_pc_plus1 <= i_pc_plus1;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus1 = r_pc_plus1;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC mux and the IF/ID register.
// Priority at each edge: branch_taken > stall > sequential fetch.
// Optional feature macro FETCH_HALT_EN: stop fetching on a 32'hFFFFFFFF word.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              halted
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_pc_next;
  pc_sel_e           w_pc_sel;
  logic              w_branch;
  logic              w_halt_hit;
  logic              w_halted;

`ifdef FETCH_HALT_EN
  logic r_halted;

  // Once halted, redirects are ignored and the PC stays frozen
  assign w_branch   = branch_taken && !r_halted;
  assign w_halt_hit = !r_halted && !w_branch && !stall && (imem_data == HALT_INSTR);
  assign w_halted   = r_halted;

  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_halted <= 1'b0;
    else if (w_halt_hit) r_halted <= 1'b1;
  end
`else
  assign w_branch   = branch_taken;
  assign w_halt_hit = 1'b0;
  assign w_halted   = 1'b0;
`endif

  assign w_pc_plus1 = r_pc + 1'b1;

  // Select the next PC source by priority
  always_comb begin
    w_pc_sel = PC_SEQ;
    if (w_branch)                             w_pc_sel = PC_REDIRECT;
    else if (stall || w_halted || w_halt_hit) w_pc_sel = PC_HOLD;
  end

  // Next-PC mux
  always_comb begin
    w_pc_next = r_pc;
    unique case (w_pc_sel)
      PC_SEQ:      w_pc_next = w_pc_plus1;
      PC_HOLD:     w_pc_next = r_pc;
      PC_REDIRECT: w_pc_next = branch_target;
      default:     w_pc_next = r_pc;
    endcase
  end

  // Program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC;
    else        r_pc <= w_pc_next;
  end

  assign imem_addr = r_pc;
  assign halted    = w_halted;

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_pc_sel == PC_SEQ),
    .i_flush    (w_branch || w_halt_hit || w_halted),
    .i_hold     (stall),
    .i_instr    (imem_data),
    .i_pc_plus1 (w_pc_plus1),
    .o_instr    (if_id_instr),
    .o_pc_plus1 (if_id_pc_plus1),
    .o_valid    (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized stall/branch
// traffic, checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [31:0] if_id_instr;
  logic [7:0]  if_id_pc_plus1;
  logic        if_id_valid;
  logic        halted;

  logic [31:0] rom [256];

  int total;
  int bad;

  // reference model state
  int          m_pc;
  logic [31:0] m_instr;
  int          m_pc1;
  logic        m_valid;
  logic        m_halted;

  fetch_stage #(
    .ADDR_W   (8),
    .RESET_PC (8'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  assign imem_data = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 32'h0; m_pc1 = 0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One clock edge of the fetch rules
  task automatic model_edge(input logic st, input logic br, input int tgt);
    if (m_halted) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (br) begin
      m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
    end else if (st) begin
      // everything holds
    end
`ifdef FETCH_HALT_EN
    else if (rom[m_pc] == 32'hFFFF_FFFF) begin
      m_halted = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
    end
`endif
    else begin
      m_instr = rom[m_pc];
      m_pc1   = (m_pc + 1) % 256;
      m_valid = 1'b1;
      m_pc    = (m_pc + 1) % 256;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  32'(imem_addr),      32'(m_pc));
    chk({tag, ".instr"}, if_id_instr,         m_instr);
    chk({tag, ".pc1"},   32'(if_id_pc_plus1), 32'(m_pc1));
    chk({tag, ".valid"}, 32'(if_id_valid),    32'(m_valid));
    chk({tag, ".halt"},  32'(halted),         32'(m_halted));
  endtask

  // Drive inputs just after an edge, advance one edge, compare after it
  task automatic step(input string tag, input logic st, input logic br, input int tgt);
    stall = st; branch_taken = br; branch_target = 8'(tgt);
    @(posedge clk);
    model_edge(st, br, tgt);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < 256; i++) rom[i] = 32'(i + 100);
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // free-running sequential fetch from RESET_PC
    for (int i = 0; i < 4; i++) step("seq", 1'b0, 1'b0, 0);
    chk("seq_instr3", if_id_instr, 32'd103);
    chk("seq_pc1_3", 32'(if_id_pc_plus1), 32'd4);
    step("seq", 1'b0, 1'b0, 0);

    // stall at PC=5
    chk("stall_pc", 32'(imem_addr), 32'd5);
    step("stall", 1'b1, 1'b0, 0);
    step("stall", 1'b1, 1'b0, 0);
    chk("stall_hold_instr", if_id_instr, 32'd104);
    chk("stall_hold_addr", 32'(imem_addr), 32'd5);
    step("resume", 1'b0, 1'b0, 0);
    chk("resume_instr", if_id_instr, 32'd105);

    // branch together with stall: branch wins
    step("br_stall", 1'b1, 1'b1, 40);
    chk("br_pc", 32'(imem_addr), 32'd40);
    chk("br_bubble", 32'(if_id_valid), 32'd0);
    step("br_after", 1'b0, 1'b0, 0);
    chk("br_target_instr", if_id_instr, 32'd140);

    // back-to-back branches, last target wins
    step("bb1", 1'b0, 1'b1, 17);
    step("bb2", 1'b0, 1'b1, 255);
    step("wrap", 1'b0, 1'b0, 0);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    chk("wrap_pc1", 32'(if_id_pc_plus1), 32'd0);
    chk("wrap_instr", if_id_instr, 32'd355);

    // asynchronous reset in the middle of a stall
    step("pre_rst", 1'b0, 1'b0, 0);
    step("pre_rst_st", 1'b1, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step("restart", 1'b0, 1'b0, 0);
    chk("restart_instr", if_id_instr, 32'd100);

    // randomized traffic over a random ROM
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
`ifdef FETCH_HALT_EN
      if (rom[i] == 32'hFFFF_FFFF) rom[i] = 32'h0;
`else
      if ((i % 37) == 5) rom[i] = 32'hFFFF_FFFF;
`endif
    end
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
           int'($urandom_range(0, 255)));
    end

`ifdef FETCH_HALT_EN
    for (int i = 0; i < 256; i++) rom[i] = 32'(i + 100);
    rom[3] = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 3; i++) step("pre_halt", 1'b0, 1'b0, 0);
    step("halt", 1'b0, 1'b0, 0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(imem_addr), 32'd3);
    step("halt_br", 1'b0, 1'b1, 10);
    chk("halt_br_ignored", 32'(imem_addr), 32'd3);
    step("halt_more", 1'b0, 1'b0, 0);
    do_reset();
    step("halt_clear", 1'b0, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
